// File: rtl/ex_result_buffer.sv
// Two-entry result FIFO between the integer ALU and the memory stage; turns
// trapping overflow into an Ov exception. `EXRB_FWD_EN adds decode bypass ports.
module ex_result_buffer #(
    parameter int         DEPTH  = 2,
    parameter logic [4:0] EXC_OV = 5'h0C
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic        in_overflow,
    input  logic        in_ov_trap,
    input  logic        in_wen,
    input  logic [4:0]  in_dest,
    input  logic [31:0] in_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_wen,
    output logic [4:0]  out_dest,
    output logic [31:0] out_pc,
    output logic        out_exc,
    output logic [4:0]  out_excode
`ifdef EXRB_FWD_EN
    ,
    output logic        fwd0_valid,
    output logic [4:0]  fwd0_dest,
    output logic [31:0] fwd0_data,
    output logic        fwd1_valid,
    output logic [4:0]  fwd1_dest,
    output logic [31:0] fwd1_data
`endif
);

    localparam logic [1:0] FULL = 2'(DEPTH);

    typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

    typedef struct packed {
        logic [31:0] result;
        logic        wen;
        logic [4:0]  dest;
        logic [31:0] pc;
        logic        exc;
    } entry_t;

    entry_t      mem_q [2];
    state_t      state_q, state_d;
    logic [1:0]  count_q, count_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        in_ready_q;
    logic        out_valid_q, out_wen_q, out_exc_q;
    logic [4:0]  out_dest_q, out_excode_q;
    logic [31:0] out_result_q, out_pc_q;

    logic        push, pop, head_from_in;
    logic [1:0]  stay;
    entry_t      in_entry, head_d;

    assign push = in_valid & in_ready_q;
    assign pop  = out_valid_q & out_ready;

    always_comb begin
        in_entry        = '0;
        in_entry.result = in_result;
        in_entry.exc    = in_ov_trap & in_overflow;
        in_entry.wen    = in_wen & ~(in_ov_trap & in_overflow) & (in_dest != 5'd0);
        in_entry.dest   = in_dest;
        in_entry.pc     = in_pc;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (flush) begin
            state_d  = RUN;
            count_d  = 2'd0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
            if (push && in_entry.exc) state_d = HOLD;
        end
    end

    // The incoming entry becomes the head only when nothing older survives this edge.
    assign stay         = count_q - {1'b0, pop};
    assign head_from_in = push && (stay == 2'd0);
    assign head_d       = head_from_in ? in_entry : mem_q[rd_ptr_d];

    always_ff @(posedge clk) begin
        if (push && !flush && !rst) mem_q[wr_ptr_q] <= in_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= RUN;
            count_q      <= 2'd0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_wen_q    <= 1'b0;
            out_exc_q    <= 1'b0;
            out_excode_q <= 5'd0;
            out_result_q <= 32'd0;
            out_dest_q   <= 5'd0;
            out_pc_q     <= 32'd0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            in_ready_q  <= (state_d == RUN) && (count_d != FULL);
            out_valid_q <= (count_d != 2'd0);
            if (count_d != 2'd0) begin
                out_result_q <= head_d.result;
                out_dest_q   <= head_d.dest;
                out_pc_q     <= head_d.pc;
                out_wen_q    <= head_d.wen;
                out_exc_q    <= head_d.exc;
                out_excode_q <= head_d.exc ? EXC_OV : 5'd0;
            end else begin
                out_wen_q    <= 1'b0;
                out_exc_q    <= 1'b0;
                out_excode_q <= 5'd0;
            end
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_wen    = out_wen_q;
    assign out_dest   = out_dest_q;
    assign out_pc     = out_pc_q;
    assign out_exc    = out_exc_q;
    assign out_excode = out_excode_q;

`ifdef EXRB_FWD_EN
    // Newest entry sits just behind the write pointer; the older one is the head when full.
    assign fwd0_valid = (count_q != 2'd0) && mem_q[~wr_ptr_q].wen;
    assign fwd0_dest  = mem_q[~wr_ptr_q].dest;
    assign fwd0_data  = mem_q[~wr_ptr_q].result;
    assign fwd1_valid = (count_q == FULL) && mem_q[rd_ptr_q].wen;
    assign fwd1_dest  = mem_q[rd_ptr_q].dest;
    assign fwd1_data  = mem_q[rd_ptr_q].result;
`endif

endmodule

// File: doc/ex_result_buffer.md
# ex_result_buffer

Execute-stage result buffer that sits directly downstream of the integer ALU. It captures the ALU result, overflow flag and instruction metadata into a 2-entry FIFO, and turns overflow on trapping instructions into an Ov exception. It presents the entries to the memory stage through a valid/ready handshake, so the ALU stage never sees a combinational path from memory-stage back-pressure.

## Interface
Parameters:
- DEPTH, 2, number of buffer entries; only 2 is supported.
- EXC_OV, 5'h0C, exception code driven for arithmetic overflow.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous and active-high.
- flush  in  1  kills all entries and clears exception hold; synchronous.
- in_valid  in  1  ALU stage offers an instruction.
- in_ready  out  1  buffer accepts this cycle.
- in_result  in  32  ALU aluout.
- in_overflow  in  1  ALU overflow flag.
- in_ov_trap  in  1  instruction traps on overflow (ADD/ADDI/SUB).
- in_wen  in  1  instruction writes a GPR.
- in_dest  in  5  destination GPR index.
- in_pc  in  32  instruction PC.
- out_valid  out  1  head entry valid.
- out_ready  in  1  memory stage consumes head.
- out_result  out  32  head result.
- out_wen  out  1  head GPR write enable (already gated).
- out_dest  out  5  head destination.
- out_pc  out  32  head PC.
- out_exc  out  1  head carries an exception.
- out_excode  out  5  exception code; 0 when out_exc=0.

## Operation
- Storage: 2 entries, rd_ptr/wr_ptr (1 bit each), count 0..2.
- Push: in_valid && in_ready. Pop: out_valid && out_ready.
- At push, the entry stores:
  - exc = in_ov_trap & in_overflow; excode = exc ? EXC_OV : 0.
  - wen = in_wen & ~exc & (in_dest != 0).
  - result, dest and pc are stored unmodified; the result is kept even when exc=1.
- State machine:
  - RUN: in_ready = (count != 2).
  - HOLD: in_ready = 0.
  - RUN -> HOLD when a push stores exc=1.
  - HOLD -> RUN only on flush or rst. Draining the entries does not leave HOLD.
- Priority: rst > flush > push/pop.
  - flush: count=0, pointers=0, state=RUN; a push or pop in the same cycle is discarded.
- Simultaneous push and pop: count unchanged, both pointers advance.
  - At count=0 a push can never bypass to the output in the same cycle.
- Outputs are driven from the head entry. With out_valid=0, out_result/out_dest/out_pc hold their last value, and out_wen=0, out_exc=0, out_excode=0.
- Output values are stable while out_valid=1 and out_ready=0.

## Timing
- Reset values: out_valid=0, out_wen=0, out_exc=0, out_excode=0, out_result=0, out_dest=0, out_pc=0, in_ready=1, state=RUN, count=0.
- Latency: instruction pushed in cycle N appears on out_* in cycle N+1.
- Throughput: 1 instruction per cycle while out_ready=1.
- in_ready depends only on registered state (count, FSM state), never combinationally on out_ready or in_valid.
- Full: with out_ready held 0, two pushes fill the buffer; in_ready=0 the following cycle. After one pop, in_ready=1 the cycle after the pop.
- Exception push in cycle N: in_ready=0 from cycle N+1 until the cycle after flush.
- Flush asserted in cycle N: out_valid=0 and in_ready=1 in cycle N+1.

## Configuration
- EXRB_FWD_EN defined: adds outputs fwd0_valid, fwd0_dest[4:0], fwd0_data[31:0] (newest entry) and fwd1_valid, fwd1_dest, fwd1_data (older entry).
  - fwdX_valid = entry valid & stored wen.
  - These outputs are driven combinationally from stored state for the decode-stage bypass.
- EXRB_FWD_EN undefined: those ports and their logic do not exist. Behaviour of all other ports is identical in both cases.

## Test plan
- Streaming: out_ready=1; push result 0x00000005 dest 3 wen=1 at cycle 1, 0x0000000A dest 4 at cycle 2 -> out_valid cycles 2–3, results in order, in_ready stays 1.
- Back-pressure: out_ready=0; push 0x11, 0x22, offer 0x33 -> in_ready=0 after the second push, 0x33 not accepted; out_ready=1 -> 0x11 then 0x22 pop; in_ready returns 1 one cycle after the first pop.
- Overflow trap: push in_result=0x80000000, in_overflow=1, in_ov_trap=1, in_wen=1, dest 8 -> out_exc=1, out_excode=0x0C, out_wen=0; in_ready=0 thereafter until flush.
- Non-trapping overflow and zero dest:
  - in_overflow=1, in_ov_trap=0 (ADDU), dest 9 -> out_exc=0, out_wen=1.
  - dest 0, wen=1 -> out_wen=0.
- Flush with a simultaneous push and pop on a full buffer -> next cycle count=0, out_valid=0, in_ready=1, and the offered instruction never appears.
- Reset mid-operation: rst with 2 entries held plus HOLD state -> all outputs at reset values the next cycle. With EXRB_FWD_EN defined, fwd0_valid and fwd1_valid are both 0 after reset.
